// File: rtl/cpuy_pkg.sv
// Shared CPU definitions: opcode encodings, opcode group codes and the
// writeback FSM state type.
package cpuy_pkg;

    // Two-operand ops: op[7]=1, op[6:2] selects the group, op[1:0] are variants
    localparam logic [4:0] GRP_ADD = 5'b00010;
    localparam logic [4:0] GRP_SUB = 5'b00011;
    localparam logic [4:0] GRP_MUL = 5'b00100;
    localparam logic [4:0] GRP_AND = 5'b00101;
    localparam logic [4:0] GRP_OR  = 5'b00110;
    localparam logic [4:0] GRP_XOR = 5'b00111;

    // Single-operand ops
    localparam logic [7:0] OP_DEC  = 8'h01;
    localparam logic [7:0] OP_INC  = 8'h02;
    localparam logic [7:0] OP_NOT  = 8'h03;
    localparam logic [7:0] OP_SETC = 8'h04;
    localparam logic [7:0] OP_CLRC = 8'h05;
    localparam logic [7:0] OP_RL   = 8'h06;
    localparam logic [7:0] OP_RR   = 8'h07;
    localparam logic [7:0] OP_RLC  = 8'h08;
    localparam logic [7:0] OP_RRC  = 8'h09;
    localparam logic [7:0] OP_SWAP = 8'h0A;

    // Bit ops: op[7]=0, op[6:3] is the prefix, op[2:0] the bit index
    localparam logic [3:0] BIT_SETB = 4'b1100;
    localparam logic [3:0] BIT_CLRB = 4'b1101;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WR_L = 2'd1,
        WB_WR_H = 2'd2,
        WB_DONE = 2'd3
    } wb_state_e;

endpackage

// File: rtl/alu_wb_decode.sv
// Opcode decoder for the ALU writeback stage.
// Ports:
//   operation - opcode being classified
//   upd_c/z/s - flag update mask for C, Z, S
//   is_mul    - MUL group, needs a second (high byte) write
//   is_two_op - two-operand op, low result goes to W
//   no_write  - flag-only or illegal, skips the write port
//   illegal   - opcode not in any supported class
module alu_wb_decode
    import cpuy_pkg::*;
(
    input  logic [7:0] operation,
    output logic       upd_c,
    output logic       upd_z,
    output logic       upd_s,
    output logic       is_mul,
    output logic       is_two_op,
    output logic       no_write,
    output logic       illegal
);

    always_comb begin
        upd_c     = 1'b0;
        upd_z     = 1'b0;
        upd_s     = 1'b0;
        is_mul    = 1'b0;
        is_two_op = 1'b0;
        no_write  = 1'b0;
        illegal   = 1'b0;
        if (operation[7] && (operation[6:1] >= 6'd4) && (operation[6:1] <= 6'd15)) begin
            is_two_op = 1'b1;
            upd_z     = 1'b1;
            case (operation[6:2])
                GRP_ADD: upd_c  = 1'b1;
                GRP_SUB: upd_s  = 1'b1;
                GRP_MUL: is_mul = 1'b1;
                default: ;
            endcase
        end else if (!operation[7] && ((operation[6:3] == BIT_SETB) ||
                                       (operation[6:3] == BIT_CLRB))) begin
            upd_z = 1'b1;
        end else if ((operation >= OP_DEC) && (operation <= OP_SWAP)) begin
            case (operation)
                OP_DEC: begin
                    upd_z = 1'b1;
                    upd_s = 1'b1;
                end
                OP_INC, OP_RLC, OP_RRC: begin
                    upd_c = 1'b1;
                    upd_z = 1'b1;
                end
                OP_SETC, OP_CLRC: begin
                    upd_c    = 1'b1;
                    no_write = 1'b1;
                end
                default: upd_z = 1'b1;
            endcase
        end else begin
            illegal  = 1'b1;
            no_write = 1'b1;
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: accepts one ALU result per handshake, writes it
// through the shared write port (two writes for MUL), commits C/Z/S flags
// under a per-opcode mask and pulses done (with illegal when applicable).
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - result handshake from the ALU
//   operation, result_l/h - opcode and result bytes
//   alu_carry/zero/sign   - ALU flags for this result
//   dest_addr             - target of single-operand and bit ops
//   wr_req/addr/data/ack  - write port, held until ack
//   flag_c/z/s            - committed flags (flag_c feeds ALU carry-in)
//   done, illegal         - one-cycle completion pulses
module alu_writeback
    import cpuy_pkg::*;
#(
    parameter int                ADDR_W = 8,
    parameter logic [ADDR_W-1:0] W_ADDR = '0,
    parameter logic [ADDR_W-1:0] H_ADDR = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        operation,
    input  logic [7:0]        result_l,
    input  logic [7:0]        result_h,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ack,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_s,
    output logic              done,
    output logic              illegal
);

    wb_state_e         state_q, state_d;
    logic              dec_upd_c, dec_upd_z, dec_upd_s;
    logic              dec_mul, dec_two_op, dec_no_write, dec_illegal;
    logic              upd_c_q, upd_z_q, upd_s_q, mul_q, illegal_q;
    logic              c_q, z_q, s_q;
    logic [7:0]        res_h_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              flag_c_q, flag_z_q, flag_s_q;
    logic              accept, enter_done;
    logic              src_upd_c, src_upd_z, src_upd_s, src_ill;
    logic              src_c, src_z, src_s;

    alu_wb_decode u_decode (
        .operation (operation),
        .upd_c     (dec_upd_c),
        .upd_z     (dec_upd_z),
        .upd_s     (dec_upd_s),
        .is_mul    (dec_mul),
        .is_two_op (dec_two_op),
        .no_write  (dec_no_write),
        .illegal   (dec_illegal)
    );

    assign in_ready   = (state_q == WB_IDLE);
    assign accept     = in_valid && in_ready;
    assign wr_req     = (state_q == WB_WR_L) || (state_q == WB_WR_H);
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign done       = (state_q == WB_DONE);
    assign illegal    = done && illegal_q;
    assign flag_c     = flag_c_q;
    assign flag_z     = flag_z_q;
    assign flag_s     = flag_s_q;
    assign enter_done = (state_d == WB_DONE) && (state_q != WB_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: if (in_valid) state_d = dec_no_write ? WB_DONE : WB_WR_L;
            WB_WR_L: if (wr_ack)   state_d = mul_q ? WB_WR_H : WB_DONE;
            WB_WR_H: if (wr_ack)   state_d = WB_DONE;
            default:               state_d = WB_IDLE;
        endcase
    end

    // Flag-only and illegal ops reach DONE straight from IDLE, before the
    // latched copies exist, so the commit takes the live decode there.
    always_comb begin
        src_upd_c = upd_c_q;
        src_upd_z = upd_z_q;
        src_upd_s = upd_s_q;
        src_ill   = illegal_q;
        src_c     = c_q;
        src_z     = z_q;
        src_s     = s_q;
        if (state_q == WB_IDLE) begin
            src_upd_c = dec_upd_c;
            src_upd_z = dec_upd_z;
            src_upd_s = dec_upd_s;
            src_ill   = dec_illegal;
            src_c     = alu_carry;
            src_z     = alu_zero;
            src_s     = alu_sign;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_IDLE;
            upd_c_q   <= 1'b0;
            upd_z_q   <= 1'b0;
            upd_s_q   <= 1'b0;
            mul_q     <= 1'b0;
            illegal_q <= 1'b0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            s_q       <= 1'b0;
            res_h_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_s_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                upd_c_q   <= dec_upd_c;
                upd_z_q   <= dec_upd_z;
                upd_s_q   <= dec_upd_s;
                mul_q     <= dec_mul;
                illegal_q <= dec_illegal;
                c_q       <= alu_carry;
                z_q       <= alu_zero;
                s_q       <= alu_sign;
                res_h_q   <= result_h;
                wr_addr_q <= dec_two_op ? W_ADDR : dest_addr;
                wr_data_q <= result_l;
            end
            if ((state_q == WB_WR_L) && wr_ack && mul_q) begin
                wr_addr_q <= H_ADDR;
                wr_data_q <= res_h_q;
            end
            if (enter_done && !src_ill) begin
                if (src_upd_c) flag_c_q <= src_c;
                if (src_upd_z) flag_z_q <= src_z;
                if (src_upd_s) flag_s_q <= src_s;
            end
        end
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream stage of the ALU.
- Captures one ALU result per handshake and writes it back through a shared register/memory write port. MUL produces two bytes, so it takes two transactions.
- Commits the architectural C/Z/S flags, using a per-opcode update mask so untouched flags are preserved.
- Drives flag_c back to the ALU carry-in.

Parameters:
- ADDR_W, 8, width of write-port address and dest_addr.
- W_ADDR, 8'h00, register-file address of W (low result of two-operand ops).
- H_ADDR, 8'h01, address receiving MUL high byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- operation  in  8  opcode that produced the result
- result_l  in  8  ALU low result
- result_h  in  8  ALU high result (MUL only)
- alu_carry  in  1  ALU carry
- alu_zero  in  1  ALU zero
- alu_sign  in  1  ALU sign
- dest_addr  in  ADDR_W  target of single-operand ops
- wr_req  out  1  write request
- wr_addr  out  ADDR_W  write address
- wr_data  out  8  write data
- wr_ack  in  1  write accepted (same or later cycle)
- flag_c  out  1  committed carry, feeds ALU carry-in
- flag_z  out  1  committed zero
- flag_s  out  1  committed sign
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse with done for unsupported opcode

Behaviour:
- Clock, reset, idle state:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - Reset drives state IDLE, in_ready=1, and wr_req=0.
  - Reset also clears wr_addr=0, wr_data=0, flag_c=flag_z=flag_s=0, done=0, illegal=0.
  - Reset mid-transaction aborts it: wr_req drops immediately and no flags commit.
- Accept:
  - Occurs on the clk edge where in_valid&in_ready.
  - Latches operation, result_l, result_h, the flags, and dest_addr.
  - in_ready=1 only in IDLE.
- Opcode classes:
  - Two-operand: op[7]=1 and op[6:1] in 000100..001111.
  - Bit ops: op[7]=0 and op[6:3] in {1100,1101}.
  - Single-operand: op in 8'h01..8'h0A.
  - Anything else is illegal.
- Destination:
  - Two-operand ops write result_l to W_ADDR.
  - MUL (op[6:1]=001000/001001) then writes result_h to H_ADDR.
  - Single-operand and bit ops write result_l to latched dest_addr.
  - SETC (8'h04) and CLRC (8'h05) are flag-only: no write.
- Flag update mask:
  - C updated only by ADD, INC, SETC, CLRC, RLC, RRC.
  - Z updated by every legal op except SETC and CLRC.
  - S updated only by SUB and DEC.
  - Flags not in the mask hold their value.
- Flag commit:
  - Flags commit on the edge entering DONE.
  - Illegal ops commit nothing and perform no write.
- FSM states: IDLE, WR_L, WR_H, DONE.
  - IDLE -> WR_L on accept of a writing op.
  - IDLE -> DONE on accept of a flag-only or illegal op.
  - WR_L: wr_req=1, wr_addr/wr_data registered and stable until wr_ack is sampled high. On ack, go to WR_H if MUL, else DONE.
  - WR_H: same handshake with H_ADDR/result_h. On ack, go to DONE.
  - DONE: done=1 (plus illegal if applicable) for exactly one cycle, then IDLE.
- Latency (accept at edge T):
  - Single write with immediate ack: wr_req high cycle T+1, done cycle T+2, in_ready again at T+3.
  - MUL with immediate acks adds one cycle.
  - Flag-only: done in cycle T+1.
- wr_ack outside WR_L/WR_H is ignored.
- wr_req never deasserts without an ack, except on reset.

Decomposition:
- Shared package cpuy_pkg:
  - Opcode constants (ADD, SUB, MUL, AND, OR, XOR groups; DEC, INC, NOT, SETC, CLRC, RL, RR, RLC, RRC, SWAP; SETB/CLRB prefixes).
  - Writeback state enum.
- Combinational sub-module alu_wb_decode maps operation to upd_c, upd_z, upd_s, is_mul, is_two_op, no_write, illegal.
- The FSM and flag registers stay in alu_writeback.

Test Plan:
- Reset, then ADD (8'h88) with result_l=8'h10, alu_carry=1, wr_ack tied high.
  - Write addr 8'h00 data 8'h10 in cycle T+1; done at T+2; flag_c=1; flag_s unchanged.
- MUL (8'h90) with result_l=8'h00, result_h=8'h3C, ack delayed 3 cycles per write.
  - Write 8'h00->W_ADDR, then 8'h3C->H_ADDR; wr_req/addr/data stable while waiting; one done pulse.
- Preset flag_c=1 via SETC (8'h04), then AND (8'h94) with alu_carry=0, alu_zero=1.
  - SETC: no wr_req, done at T+1.
  - AND: flag_z=1, flag_c stays 1.
- SUB (8'h8C) with alu_sign=1, result_l=8'h05, then NOT (8'h03) with alu_sign=0.
  - flag_s=1 after SUB and still 1 after NOT.
- Opcode 8'h7F: no write, flags unchanged, done and illegal pulse together for one cycle.
- Assert rst_n low while in WR_L waiting for ack.
  - wr_req=0 immediately; flags=0; in_ready=1 after release; a late wr_ack is ignored.
